// File: rtl/pass_entry_ctrl.sv
// Keypad front end: three push-buttons build a 3-digit BCD code that is checked against the user or default password.
// Optional macro DEBOUNCE_EN adds a per-button stable-time filter (DB_CYC cycles) behind the synchroniser.
module pass_entry_ctrl #(
  parameter logic [11:0] USR_RST  = 12'h123,
`ifdef DEBOUNCE_EN
  parameter logic [19:0] DB_CYC   = 20'd500000,
`endif
  parameter logic [11:0] DEF_PASS = 12'h987
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  input  logic       btn_set,
  input  logic       mode_def,
  input  logic       enb_frequency,
  output logic [3:0] mod10_out,
  output logic [1:0] mod3_out,
  output logic       enter,
  output logic       lock_rst,
  output logic       unlocked,
  output logic       setpw
);

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_SETPW    = 2'd3
  } state_t;

  // Button bit order everywhere: 0 inc, 1 next, 2 enter, 3 set.
  logic [3:0]  w_btnRaw;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  w_btnLevel;
  logic [3:0]  r_btnPrev;
  logic [3:0]  r_btnEvt;
  logic [3:0]  w_evValid;
  logic        w_evGate;
  logic        w_evInc;
  logic        w_evNext;
  logic        w_evEnter;
  logic        w_evSet;
  logic        r_enbPrev;
  logic        w_enbFall;

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_edit;
  logic        w_doClear;
  logic        w_bufWrite;
  logic        w_match;

  logic [11:0] r_buffer;
  logic [11:0] r_usrPass;
  logic [11:0] w_bufMerged;
  logic [11:0] w_refPass;
  logic [3:0]  r_mod10;
  logic [1:0]  r_mod3;
  logic        r_enter;
  logic        r_lockRst;

  assign w_btnRaw = {btn_set, btn_enter, btn_next, btn_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btnRaw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  logic [19:0] r_dbCnt [4];
  logic [3:0]  r_dbLevel;

  // A level change is accepted only after the new value held for DB_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbLevel <= '0;
      for (int i = 0; i < 4; i++) r_dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_dbLevel[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] + 20'd1 >= DB_CYC) begin
          r_dbLevel[i] <= r_sync2[i];
          r_dbCnt[i]   <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + 20'd1;
        end
      end
    end
  end

  assign w_btnLevel = r_dbLevel;
`else
  assign w_btnLevel = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btnPrev <= '0;
      r_btnEvt  <= '0;
      r_enbPrev <= 1'b0;
    end else begin
      r_btnPrev <= w_btnLevel;
      r_btnEvt  <= w_btnLevel & ~r_btnPrev;
      r_enbPrev <= enb_frequency;
    end
  end

  // The cycle the countdown ends only clears the entry; any event landing then is dropped too.
  assign w_enbFall = r_enbPrev & ~enb_frequency;
  assign w_evGate  = ~enb_frequency & ~w_enbFall;
  assign w_evValid = r_btnEvt & {4{w_evGate}};

  assign w_evEnter = w_evValid[2];
  assign w_evSet   = w_evValid[3] & ~w_evValid[2];
  assign w_evNext  = w_evValid[1] & ~w_evValid[2] & ~w_evValid[3];
  assign w_evInc   = w_evValid[0] & ~w_evValid[1] & ~w_evValid[2] & ~w_evValid[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ENTRY;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_ENTRY: begin
        if (w_evEnter) w_stateNext = ST_CHECK;
      end
      ST_CHECK: begin
        w_stateNext = w_match ? ST_UNLOCKED : ST_ENTRY;
      end
      ST_UNLOCKED: begin
        if (w_evEnter)    w_stateNext = ST_ENTRY;
        else if (w_evSet) w_stateNext = ST_SETPW;
      end
      ST_SETPW: begin
        if (w_evEnter)    w_stateNext = ST_ENTRY;
        else if (w_evSet) w_stateNext = ST_UNLOCKED;
      end
      default: w_stateNext = ST_ENTRY;
    endcase
  end

  always_comb begin
    unlocked = 1'b0;
    setpw    = 1'b0;
    w_edit   = 1'b0;
    case (r_state)
      ST_ENTRY:    w_edit   = 1'b1;
      ST_UNLOCKED: unlocked = 1'b1;
      ST_SETPW: begin
        setpw  = 1'b1;
        w_edit = 1'b1;
      end
      default: ;
    endcase
  end

  // The first typed digit lands in the top nibble, so keying 1,2,3 reads as 12'h123.
  always_comb begin
    w_bufMerged = r_buffer;
    case (r_mod3)
      2'd0:    w_bufMerged[11:8] = r_mod10;
      2'd1:    w_bufMerged[7:4]  = r_mod10;
      default: w_bufMerged[3:0]  = r_mod10;
    endcase
  end

  assign w_refPass  = mode_def ? DEF_PASS : r_usrPass;
  assign w_match    = (r_buffer == w_refPass);
  assign w_bufWrite = w_edit & (w_evNext | (w_evEnter & (r_state == ST_ENTRY)));
  assign w_doClear  = w_enbFall
                    | (r_state == ST_CHECK)
                    | (((r_state == ST_UNLOCKED) | (r_state == ST_SETPW)) & (w_evEnter | w_evSet));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buffer <= '0;
      r_mod10  <= '0;
      r_mod3   <= '0;
    end else if (w_doClear) begin
      r_buffer <= '0;
      r_mod10  <= '0;
      r_mod3   <= '0;
    end else begin
      if (w_bufWrite) r_buffer <= w_bufMerged;
      if (w_edit && w_evNext) begin
        r_mod10 <= 4'd0;
        r_mod3  <= (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
      end else if (w_edit && w_evInc) begin
        r_mod10 <= (r_mod10 == 4'd9) ? 4'd0 : r_mod10 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_usrPass <= USR_RST;
    end else if ((r_state == ST_SETPW) && w_evEnter) begin
      r_usrPass <= w_bufMerged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enter   <= 1'b0;
      r_lockRst <= 1'b0;
    end else begin
      r_enter   <= (r_state == ST_CHECK) & ~w_match;
      r_lockRst <= (r_state == ST_CHECK) &  w_match;
    end
  end

  assign mod10_out = r_mod10;
  assign mod3_out  = r_mod3;
  assign enter     = r_enter;
  assign lock_rst  = r_lockRst;

endmodule

// File: tb/tb_pass_entry_ctrl.sv
// Self-checking bench for pass_entry_ctrl: a press-level model predicts every output each cycle,
// and directed literal checks pin the key scenarios (default build, no debounce).
module tb_pass_entry_ctrl;

  localparam logic [3:0] BT_INC   = 4'b0001;
  localparam logic [3:0] BT_NEXT  = 4'b0010;
  localparam logic [3:0] BT_ENTER = 4'b0100;
  localparam logic [3:0] BT_SET   = 4'b1000;
  localparam int         LATENCY  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_inc, btn_next, btn_enter, btn_set;
  logic       mode_def, enb_frequency;
  logic [3:0] mod10_out;
  logic [1:0] mod3_out;
  logic       enter, lock_rst, unlocked, setpw;

  pass_entry_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_inc       (btn_inc),
    .btn_next      (btn_next),
    .btn_enter     (btn_enter),
    .btn_set       (btn_set),
    .mode_def      (mode_def),
    .enb_frequency (enb_frequency),
    .mod10_out     (mod10_out),
    .mod3_out      (mod3_out),
    .enter         (enter),
    .lock_rst      (lock_rst),
    .unlocked      (unlocked),
    .setpw         (setpw)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } press_t;

  typedef enum int {M_ENTRY, M_CHECK, M_UNLOCKED, M_SETPW} mstate_t;

  press_t      pressQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          enterCnt = 0;
  int          lockCnt = 0;
  bit          cmpEn = 1'b0;

  mstate_t     mState;
  int          mDigit, mPos;
  int          mBuf[3];
  logic [11:0] mUsr;
  bit          mEnter, mLock, mEnbPrev;
  int          mNow;
  logic [3:0]  mDue;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] codeOf();
    return 12'(mBuf[0] * 256 + mBuf[1] * 16 + mBuf[2]);
  endfunction

  task automatic clearEntry();
    mDigit = 0;
    mPos   = 0;
    for (int i = 0; i < 3; i++) mBuf[i] = 0;
  endtask

  task automatic modelEvent(input logic [3:0] m);
    logic [3:0] ev;
    ev = m[2] ? BT_ENTER : m[3] ? BT_SET : m[1] ? BT_NEXT : m[0] ? BT_INC : 4'b0000;
    case (mState)
      M_ENTRY, M_SETPW: begin
        if (ev == BT_INC) begin
          mDigit = (mDigit + 1) % 10;
        end else if (ev == BT_NEXT) begin
          mBuf[mPos] = mDigit;
          mPos = (mPos + 1) % 3;
          mDigit = 0;
        end else if (ev == BT_ENTER && mState == M_ENTRY) begin
          mBuf[mPos] = mDigit;
          mState = M_CHECK;
        end else if (ev == BT_ENTER) begin
          mBuf[mPos] = mDigit;
          mUsr = codeOf();
          mState = M_ENTRY;
          clearEntry();
        end else if (ev == BT_SET && mState == M_SETPW) begin
          mState = M_UNLOCKED;
          clearEntry();
        end
      end
      M_UNLOCKED: begin
        if (ev == BT_ENTER) begin
          mState = M_ENTRY;
          clearEntry();
        end else if (ev == BT_SET) begin
          mState = M_SETPW;
          clearEntry();
        end
      end
      default: ;
    endcase
  endtask

  // Each press takes effect LATENCY edges after the raw button rose; the check result follows one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState   = M_ENTRY;
      mUsr     = 12'h123;
      mEnter   = 1'b0;
      mLock    = 1'b0;
      mEnbPrev = 1'b0;
      clearEntry();
      pressQ.delete();
    end else begin
      mNow = cyc + 1;
      mDue = 4'b0000;
      while (pressQ.size() > 0 && pressQ[0].cyc + LATENCY <= mNow) begin
        if (pressQ[0].cyc + LATENCY == mNow) mDue = mDue | pressQ[0].mask;
        pressQ.delete(0);
      end
      mEnter = 1'b0;
      mLock  = 1'b0;
      if (mState == M_CHECK) begin
        if (codeOf() == (mode_def ? 12'h987 : mUsr)) begin
          mLock  = 1'b1;
          mState = M_UNLOCKED;
        end else begin
          mEnter = 1'b1;
          mState = M_ENTRY;
        end
        clearEntry();
      end else if (mEnbPrev && !enb_frequency) begin
        clearEntry();
      end else if (!enb_frequency && mDue != 4'b0000) begin
        modelEvent(mDue);
      end
      mEnbPrev = enb_frequency;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmpEn) begin
      checkOutput("mod10_out", 32'(mod10_out), 32'(mDigit));
      checkOutput("mod3_out",  32'(mod3_out),  32'(mPos));
      checkOutput("enter",     32'(enter),     32'(mEnter));
      checkOutput("lock_rst",  32'(lock_rst),  32'(mLock));
      checkOutput("unlocked",  32'(unlocked),  32'(mState == M_UNLOCKED));
      checkOutput("setpw",     32'(setpw),     32'(mState == M_SETPW));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (enter === 1'b1)    enterCnt++;
      if (lock_rst === 1'b1) lockCnt++;
    end
  end

  task automatic applyStimulus(input logic [3:0] mask, input int settle);
    press_t p;
    @(posedge clk); #1;
    p.cyc  = cyc;
    p.mask = mask;
    pressQ.push_back(p);
    {btn_set, btn_enter, btn_next, btn_inc} = mask;
    repeat (2) @(posedge clk);
    #1;
    {btn_set, btn_enter, btn_next, btn_inc} = 4'b0000;
    repeat (settle) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    applyStimulus(mask, 4);
  endtask

  task automatic keyDigit(input int d);
    for (int i = 0; i < d; i++) press(BT_INC);
  endtask

  task automatic typeCode(input int a, input int b, input int c);
    keyDigit(a);
    press(BT_NEXT);
    keyDigit(b);
    press(BT_NEXT);
    keyDigit(c);
    press(BT_ENTER);
  endtask

  task automatic clearCounts();
    @(posedge clk); #1;
    enterCnt = 0;
    lockCnt  = 0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_mod10"},    32'(mod10_out), 32'd0);
    checkOutput({tag, "_mod3"},     32'(mod3_out),  32'd0);
    checkOutput({tag, "_enter"},    32'(enter),     32'd0);
    checkOutput({tag, "_lock_rst"}, 32'(lock_rst),  32'd0);
    checkOutput({tag, "_unlocked"}, 32'(unlocked),  32'd0);
    checkOutput({tag, "_setpw"},    32'(setpw),     32'd0);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {btn_set, btn_enter, btn_next, btn_inc} = 4'b0000;
    mode_def = 1'b0;
    enb_frequency = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst_n = 1'b1;
    cmpEn = 1'b1;

    $display("[TB] T1 default user code 1,2,3");
    clearCounts();
    typeCode(1, 2, 3);
    checkOutput("t1_lock_cnt",  32'(lockCnt),  32'd1);
    checkOutput("t1_enter_cnt", 32'(enterCnt), 32'd0);
    checkOutput("t1_unlocked",  32'(unlocked), 32'd1);

    $display("[TB] T2 relock then wrong code 1,2,4");
    clearCounts();
    press(BT_ENTER);
    checkOutput("t2_relocked",   32'(unlocked), 32'd0);
    checkOutput("t2_relock_cnt", 32'(enterCnt + lockCnt), 32'd0);
    typeCode(1, 2, 4);
    checkOutput("t2_enter_cnt", 32'(enterCnt), 32'd1);
    checkOutput("t2_mod3",      32'(mod3_out), 32'd0);
    checkOutput("t2_mod10",     32'(mod10_out), 32'd0);
    checkOutput("t2_unlocked",  32'(unlocked), 32'd0);

    $display("[TB] T3 digit and position wrap");
    keyDigit(9);
    checkOutput("t3_mod10_nine", 32'(mod10_out), 32'd9);
    press(BT_INC);
    checkOutput("t3_mod10_wrap", 32'(mod10_out), 32'd0);
    press(BT_NEXT);
    checkOutput("t3_mod3_1", 32'(mod3_out), 32'd1);
    press(BT_NEXT);
    checkOutput("t3_mod3_2", 32'(mod3_out), 32'd2);
    press(BT_NEXT);
    checkOutput("t3_mod3_0", 32'(mod3_out), 32'd0);
    clearCounts();
    press(BT_ENTER);
    checkOutput("t3_zero_code_cnt", 32'(enterCnt), 32'd1);

    $display("[TB] T4 set new password 5,5,5");
    typeCode(1, 2, 3);
    press(BT_SET);
    checkOutput("t4_setpw", 32'(setpw), 32'd1);
    clearCounts();
    typeCode(5, 5, 5);
    checkOutput("t4_commit_setpw",  32'(setpw), 32'd0);
    checkOutput("t4_commit_unlock", 32'(unlocked), 32'd0);
    checkOutput("t4_commit_pulses", 32'(enterCnt + lockCnt), 32'd0);
    typeCode(5, 5, 5);
    checkOutput("t4_new_lock_cnt", 32'(lockCnt), 32'd1);
    press(BT_ENTER);
    typeCode(1, 2, 3);
    checkOutput("t4_old_enter_cnt", 32'(enterCnt), 32'd1);

    $display("[TB] T4b set abort and priority");
    typeCode(5, 5, 5);
    press(BT_SET);
    keyDigit(7);
    checkOutput("t4b_edit_mod10", 32'(mod10_out), 32'd7);
    press(BT_SET);
    checkOutput("t4b_abort_unlocked", 32'(unlocked), 32'd1);
    checkOutput("t4b_abort_mod10",    32'(mod10_out), 32'd0);
    press(BT_ENTER | BT_SET);
    checkOutput("t4b_enter_wins_unlocked", 32'(unlocked), 32'd0);
    checkOutput("t4b_enter_wins_setpw",    32'(setpw), 32'd0);
    clearCounts();
    typeCode(5, 5, 5);
    checkOutput("t4b_kept_lock_cnt", 32'(lockCnt), 32'd1);
    press(BT_ENTER);
    keyDigit(3);
    press(BT_INC | BT_NEXT);
    checkOutput("t4b_next_wins_mod3",  32'(mod3_out), 32'd1);
    checkOutput("t4b_next_wins_mod10", 32'(mod10_out), 32'd0);
    clearCounts();
    press(BT_ENTER | BT_SET);
    checkOutput("t4b_enter_set_cnt", 32'(enterCnt), 32'd1);

    $display("[TB] T5 default password");
    clearCounts();
    keyDigit(9);
    press(BT_NEXT);
    keyDigit(8);
    press(BT_NEXT);
    @(posedge clk); #1;
    mode_def = 1'b1;
    keyDigit(7);
    press(BT_ENTER);
    checkOutput("t5_def_lock_cnt", 32'(lockCnt), 32'd1);
    press(BT_ENTER);
    clearCounts();
    typeCode(5, 5, 5);
    checkOutput("t5_usr_in_def_cnt", 32'(enterCnt), 32'd1);
    @(posedge clk); #1;
    mode_def = 1'b0;
    clearCounts();
    typeCode(5, 5, 5);
    checkOutput("t5_usr_kept_cnt", 32'(lockCnt), 32'd1);
    press(BT_ENTER);

    $display("[TB] T6 countdown blocking and reset during check");
    clearCounts();
    keyDigit(2);
    @(posedge clk); #1;
    enb_frequency = 1'b1;
    press(BT_INC);
    press(BT_ENTER);
    checkOutput("t6_blocked_mod10",  32'(mod10_out), 32'd2);
    checkOutput("t6_blocked_pulses", 32'(enterCnt + lockCnt), 32'd0);
    @(posedge clk); #1;
    enb_frequency = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_fall_mod10", 32'(mod10_out), 32'd0);
    checkOutput("t6_fall_mod3",  32'(mod3_out), 32'd0);
    press(BT_INC);
    press(BT_NEXT);
    keyDigit(2);
    clearCounts();
    applyStimulus(BT_ENTER, 2);
    checkOutput("t6_pre_mod3",  32'(mod3_out), 32'd1);
    checkOutput("t6_pre_mod10", 32'(mod10_out), 32'd2);
    rst_n = 1'b0;
    #1;
    checkIdle("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6_no_pulse_cnt", 32'(enterCnt + lockCnt), 32'd0);
    clearCounts();
    typeCode(1, 2, 3);
    checkOutput("t6_usr_restored_cnt", 32'(lockCnt), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
